// File: rtl/riscv_pkg.sv
// Shared RV32I decode definitions: opcodes, ALU/result encodings, immediate formats
// and the ID/EX pipeline record.
package riscv_pkg;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    ALU_ADD   = 4'h0,
    ALU_SUB   = 4'h1,
    ALU_AND   = 4'h2,
    ALU_OR    = 4'h3,
    ALU_XOR   = 4'h4,
    ALU_SLT   = 4'h5,
    ALU_SLTU  = 4'h6,
    ALU_SLL   = 4'h7,
    ALU_SRL   = 4'h8,
    ALU_SRA   = 4'h9,
    ALU_PASSB = 4'hA
  } alu_ctrl_e;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_type_e;

  typedef struct packed {
    logic        reg_write;
    logic        mem_write;
    logic        branch;
    logic        jump;
    logic        jalr;
    logic        alu_src;
    logic        alu_src_a;
    logic [1:0]  result_src;
    alu_ctrl_e   alu_ctrl;
    logic [2:0]  funct3;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [31:0] pc4;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
  } idex_t;

  function automatic logic [31:0] imm_gen(input logic [31:0] instr, input imm_type_e t);
    logic [31:0] imm;
    case (t)
      IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
      IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      IMM_U:   imm = {instr[31:12], 12'b0};
      IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

  // Bit 30 selects SUB only for register-register; shifts use it for both R and I forms.
  function automatic alu_ctrl_e alu_dec(input logic [2:0] f3, input logic f7b5, input logic is_r);
    alu_ctrl_e op;
    case (f3)
      3'b000:  op = (is_r && f7b5) ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = f7b5 ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/reg_file.sv
// 32x32 register file: two asynchronous reads, one write per cycle, x0 hardwired to zero.
module reg_file #(
  parameter bit RF_CLEAR_ON_RST = 1'b1,
  parameter bit WB_BYPASS       = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_we,
  input  logic [4:0]  i_wa,
  input  logic [31:0] i_wd,
  input  logic [4:0]  i_ra1,
  input  logic [4:0]  i_ra2,
  output logic [31:0] o_rd1,
  output logic [31:0] o_rd2
);

  logic [31:0] r_regs [32];
  logic        w_wr;

  assign w_wr = i_we && (i_wa != '0);

  generate
    if (RF_CLEAR_ON_RST) begin : g_rst
      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          for (int unsigned i = 0; i < 32; i++) r_regs[i] <= '0;
        end else if (w_wr) begin
          r_regs[i_wa] <= i_wd;
        end
      end
    end else begin : g_norst
      always_ff @(posedge i_clk) begin
        if (w_wr) r_regs[i_wa] <= i_wd;
      end
    end
  endgenerate

  always_comb begin
    o_rd1 = (i_ra1 == '0) ? '0 : r_regs[i_ra1];
    o_rd2 = (i_ra2 == '0) ? '0 : r_regs[i_ra2];
    if (WB_BYPASS && w_wr && (i_wa == i_ra1)) o_rd1 = i_wd;
    if (WB_BYPASS && w_wr && (i_wa == i_ra2)) o_rd2 = i_wd;
  end

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: register file, main/ALU decode, immediate generation,
// load-use stall and taken-branch squash feeding the ID/EX register.
module decode_stage
  import riscv_pkg::*;
#(
  parameter bit RF_CLEAR_ON_RST = 1'b1,
  parameter bit WB_BYPASS       = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] InstrD,
  input  logic [31:0] PCD,
  input  logic [31:0] PCPlus4D,
  input  logic        PCSrcE,
  input  logic        RegWriteW,
  input  logic [4:0]  RdW,
  input  logic [31:0] ResultW,
  output logic        PCWrite,
  output logic        IF_ID_Write,
  output logic [4:0]  Rs1D,
  output logic [4:0]  Rs2D,
  output logic        RegWriteE,
  output logic        MemWriteE,
  output logic        BranchE,
  output logic        JumpE,
  output logic        JalrE,
  output logic        ALUSrcE,
  output logic        ALUSrcAE,
  output logic [1:0]  ResultSrcE,
  output logic [3:0]  ALUControlE,
  output logic [2:0]  Funct3E,
  output logic [31:0] RD1E,
  output logic [31:0] RD2E,
  output logic [31:0] ImmExtE,
  output logic [31:0] PCE,
  output logic [31:0] PCPlus4E,
  output logic [4:0]  Rs1E,
  output logic [4:0]  Rs2E,
  output logic [4:0]  RdE
);

  idex_t     r_idex;
  logic      r_kill;
  idex_t     w_dec;
  logic      w_dec_ok;
  imm_type_e w_imm_type;
  logic [31:0] w_rd1, w_rd2;
  logic      w_valid_d, w_stall;

  assign Rs1D = InstrD[19:15];
  assign Rs2D = InstrD[24:20];

  reg_file #(
    .RF_CLEAR_ON_RST(RF_CLEAR_ON_RST),
    .WB_BYPASS      (WB_BYPASS)
  ) u_rf (
    .i_clk  (clk),
    .i_rst_n(rst_n),
    .i_we   (RegWriteW),
    .i_wa   (RdW),
    .i_wd   (ResultW),
    .i_ra1  (Rs1D),
    .i_ra2  (Rs2D),
    .o_rd1  (w_rd1),
    .o_rd2  (w_rd2)
  );

  always_comb begin
    w_dec          = '0;
    w_dec_ok       = 1'b1;
    w_imm_type     = IMM_NONE;
    w_dec.funct3   = InstrD[14:12];
    w_dec.rd1      = w_rd1;
    w_dec.rd2      = w_rd2;
    w_dec.pc       = PCD;
    w_dec.pc4      = PCPlus4D;
    w_dec.rs1      = Rs1D;
    w_dec.rs2      = Rs2D;
    w_dec.rd       = InstrD[11:7];
    w_dec.alu_ctrl = ALU_ADD;
    case (InstrD[6:0])
      OP_LOAD:   begin w_dec.reg_write = 1'b1; w_dec.alu_src = 1'b1; w_dec.result_src = RES_MEM; w_imm_type = IMM_I; end
      OP_STORE:  begin w_dec.mem_write = 1'b1; w_dec.alu_src = 1'b1; w_imm_type = IMM_S; end
      OP_R:      begin w_dec.reg_write = 1'b1; w_dec.alu_ctrl = alu_dec(InstrD[14:12], InstrD[30], 1'b1); end
      OP_I:      begin
        w_dec.reg_write = 1'b1; w_dec.alu_src = 1'b1; w_imm_type = IMM_I;
        w_dec.alu_ctrl  = alu_dec(InstrD[14:12], InstrD[30], 1'b0);
      end
      OP_BRANCH: begin w_dec.branch = 1'b1; w_dec.alu_ctrl = ALU_SUB; w_imm_type = IMM_B; end
      OP_JAL:    begin w_dec.reg_write = 1'b1; w_dec.jump = 1'b1; w_dec.result_src = RES_PC4; w_imm_type = IMM_J; end
      OP_JALR:   begin
        w_dec.reg_write = 1'b1; w_dec.jalr = 1'b1; w_dec.alu_src = 1'b1;
        w_dec.result_src = RES_PC4; w_imm_type = IMM_I;
      end
      OP_LUI:    begin w_dec.reg_write = 1'b1; w_dec.alu_src = 1'b1; w_dec.alu_ctrl = ALU_PASSB; w_imm_type = IMM_U; end
      OP_AUIPC:  begin w_dec.reg_write = 1'b1; w_dec.alu_src = 1'b1; w_dec.alu_src_a = 1'b1; w_imm_type = IMM_U; end
      default:   w_dec_ok = 1'b0;
    endcase
    w_dec.imm = imm_gen(InstrD, w_imm_type);
  end

  // The instruction in D is wrong-path for one cycle after a redirect, since fetch is not flushed.
  assign w_valid_d   = !r_kill;
  assign w_stall     = w_valid_d && (r_idex.result_src == RES_MEM) && (r_idex.rd != '0) &&
                       ((r_idex.rd == Rs1D) || (r_idex.rd == Rs2D));
  assign PCWrite     = !(w_stall && !PCSrcE);
  assign IF_ID_Write = !(w_stall && !PCSrcE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idex <= '0;
      r_kill <= 1'b0;
    end else begin
      r_kill <= PCSrcE;
      if (PCSrcE || !w_valid_d || w_stall || !w_dec_ok) r_idex <= '0;
      else                                             r_idex <= w_dec;
    end
  end

  assign RegWriteE   = r_idex.reg_write;
  assign MemWriteE   = r_idex.mem_write;
  assign BranchE     = r_idex.branch;
  assign JumpE       = r_idex.jump;
  assign JalrE       = r_idex.jalr;
  assign ALUSrcE     = r_idex.alu_src;
  assign ALUSrcAE    = r_idex.alu_src_a;
  assign ResultSrcE  = r_idex.result_src;
  assign ALUControlE = r_idex.alu_ctrl;
  assign Funct3E     = r_idex.funct3;
  assign RD1E        = r_idex.rd1;
  assign RD2E        = r_idex.rd2;
  assign ImmExtE     = r_idex.imm;
  assign PCE         = r_idex.pc;
  assign PCPlus4E    = r_idex.pc4;
  assign Rs1E        = r_idex.rs1;
  assign Rs2E        = r_idex.rs2;
  assign RdE         = r_idex.rd;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: decode, immediates, bypass, load-use stall, squash, reset.
module tb_decode_stage;

  logic        clk;
  logic        rst_n;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        PCSrcE, RegWriteW;
  logic [4:0]  RdW;
  logic [31:0] ResultW;
  logic        PCWrite, IF_ID_Write;
  logic [4:0]  Rs1D, Rs2D;
  logic        RegWriteE, MemWriteE, BranchE, JumpE, JalrE, ALUSrcE, ALUSrcAE;
  logic [1:0]  ResultSrcE;
  logic [3:0]  ALUControlE;
  logic [2:0]  Funct3E;
  logic [31:0] RD1E, RD2E, ImmExtE, PCE, PCPlus4E;
  logic [4:0]  Rs1E, Rs2E, RdE;

  int total = 0;
  int bad   = 0;

  decode_stage #(
    .RF_CLEAR_ON_RST(1'b1),
    .WB_BYPASS      (1'b1)
  ) dut (
    .clk(clk), .rst_n(rst_n), .InstrD(InstrD), .PCD(PCD), .PCPlus4D(PCPlus4D),
    .PCSrcE(PCSrcE), .RegWriteW(RegWriteW), .RdW(RdW), .ResultW(ResultW),
    .PCWrite(PCWrite), .IF_ID_Write(IF_ID_Write), .Rs1D(Rs1D), .Rs2D(Rs2D),
    .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .BranchE(BranchE), .JumpE(JumpE),
    .JalrE(JalrE), .ALUSrcE(ALUSrcE), .ALUSrcAE(ALUSrcAE), .ResultSrcE(ResultSrcE),
    .ALUControlE(ALUControlE), .Funct3E(Funct3E), .RD1E(RD1E), .RD2E(RD2E),
    .ImmExtE(ImmExtE), .PCE(PCE), .PCPlus4E(PCPlus4E), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1; InstrD = '0; PCD = '0; PCPlus4D = '0; PCSrcE = 1'b0;
    RegWriteW = 1'b0; RdW = '0; ResultW = '0;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_regwrite", 32'(RegWriteE), 32'd0);
    chk("rst_rde", 32'(RdE), 32'd0);
    chk("rst_imm", ImmExtE, 32'd0);
    chk("rst_pcwrite", 32'(PCWrite), 32'd1);
    chk("rst_ifid", 32'(IF_ID_Write), 32'd1);
    #1 rst_n = 1'b1;

    // addi x5,x0,-3
    InstrD = 32'hFFD00293; PCD = 32'h100; PCPlus4D = 32'h104;
    step();
    chk("addi_regwrite", 32'(RegWriteE), 32'd1);
    chk("addi_alusrc", 32'(ALUSrcE), 32'd1);
    chk("addi_imm", ImmExtE, 32'hFFFFFFFD);
    chk("addi_rd", 32'(RdE), 32'd5);
    chk("addi_aluctl", 32'(ALUControlE), 32'd0);
    chk("addi_pc", PCE, 32'h100);
    chk("addi_pc4", PCPlus4E, 32'h104);

    // addi x9,x7,0 while WB writes x7=0x1234
    InstrD = 32'h00038493; RegWriteW = 1'b1; RdW = 5'd7; ResultW = 32'h1234;
    step();
    chk("bypass_rd1", RD1E, 32'h1234);
    chk("bypass_rs1e", 32'(Rs1E), 32'd7);

    // write to x0 is ignored, also through the bypass
    InstrD = 32'h00000493; RdW = 5'd0; ResultW = 32'hDEAD;
    step();
    chk("x0_rd1", RD1E, 32'd0);

    // sub x11,x7,x7 reads the stored x7
    RegWriteW = 1'b0; InstrD = 32'h407385B3;
    step();
    chk("sub_rd1", RD1E, 32'h1234);
    chk("sub_rd2", RD2E, 32'h1234);
    chk("sub_aluctl", 32'(ALUControlE), 32'd1);
    chk("sub_alusrc", 32'(ALUSrcE), 32'd0);

    // sw x5,-4(x2)
    InstrD = 32'hFE512E23;
    step();
    chk("sw_imm", ImmExtE, 32'hFFFFFFFC);
    chk("sw_memwrite", 32'(MemWriteE), 32'd1);
    chk("sw_regwrite", 32'(RegWriteE), 32'd0);

    // beq x0,x0,-8
    InstrD = 32'hFE000CE3;
    step();
    chk("beq_imm", ImmExtE, 32'hFFFFFFF8);
    chk("beq_branch", 32'(BranchE), 32'd1);
    chk("beq_aluctl", 32'(ALUControlE), 32'd1);

    // jal x1,+2048
    InstrD = 32'h001000EF;
    step();
    chk("jal_imm", ImmExtE, 32'h00000800);
    chk("jal_jump", 32'(JumpE), 32'd1);
    chk("jal_ressrc", 32'(ResultSrcE), 32'd2);

    // lui x3,0x12345
    InstrD = 32'h123451B7;
    step();
    chk("lui_imm", ImmExtE, 32'h12345000);
    chk("lui_aluctl", 32'(ALUControlE), 32'hA);

    // auipc x4,1
    InstrD = 32'h00001217;
    step();
    chk("auipc_srca", 32'(ALUSrcAE), 32'd1);
    chk("auipc_imm", ImmExtE, 32'h00001000);

    // jalr x0,0(x1)
    InstrD = 32'h00008067;
    step();
    chk("jalr_flag", 32'(JalrE), 32'd1);
    chk("jalr_ressrc", 32'(ResultSrcE), 32'd2);

    // undefined opcode with rd field = 6
    InstrD = 32'h0000037F;
    step();
    chk("undef_regwrite", 32'(RegWriteE), 32'd0);
    chk("undef_rd", 32'(RdE), 32'd0);

    // lw x6,0(x1) then add x8,x6,x1
    InstrD = 32'h0000A303;
    step();
    chk("lw_ressrc", 32'(ResultSrcE), 32'd1);
    chk("lw_rd", 32'(RdE), 32'd6);
    InstrD = 32'h00130433;
    #1;
    chk("lu_pcwrite", 32'(PCWrite), 32'd0);
    chk("lu_ifid", 32'(IF_ID_Write), 32'd0);
    step();
    chk("lu_bubble_rw", 32'(RegWriteE), 32'd0);
    chk("lu_bubble_rd", 32'(RdE), 32'd0);
    chk("lu_release", 32'(PCWrite), 32'd1);
    step();
    chk("lu_issue_rw", 32'(RegWriteE), 32'd1);
    chk("lu_issue_rs1", 32'(Rs1E), 32'd6);
    chk("lu_issue_rd", 32'(RdE), 32'd8);

    // taken branch: squash this cycle and the next
    InstrD = 32'hFFD00293; PCSrcE = 1'b1;
    #1;
    chk("br_pcwrite", 32'(PCWrite), 32'd1);
    step();
    chk("br_bubble1", 32'(RegWriteE), 32'd0);
    PCSrcE = 1'b0;
    step();
    chk("br_bubble2", 32'(RegWriteE), 32'd0);
    InstrD = 32'h123451B7;
    step();
    chk("br_target_rw", 32'(RegWriteE), 32'd1);
    chk("br_target_imm", ImmExtE, 32'h12345000);

    // reset asserted in the middle of a load-use stall
    InstrD = 32'h0000A303;
    step();
    InstrD = 32'h00130433;
    #1;
    chk("rs_stall_on", 32'(PCWrite), 32'd0);
    #1 rst_n = 1'b0;
    #1;
    chk("rs_regwrite", 32'(RegWriteE), 32'd0);
    chk("rs_ressrc", 32'(ResultSrcE), 32'd0);
    chk("rs_rd", 32'(RdE), 32'd0);
    chk("rs_pcwrite", 32'(PCWrite), 32'd1);
    step();
    rst_n = 1'b1;
    InstrD = 32'hFFD00293;
    step();
    chk("post_rst_rw", 32'(RegWriteE), 32'd1);
    chk("post_rst_imm", ImmExtE, 32'hFFFFFFFD);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
